// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_sequencer
//  Description : Steps a test-pattern generator through its pattern indices.
//                Patterns change only on a frame start (rising edge of
//                i_VSync). Advances come from manual steps (i_Step, collapsed
//                to one per frame) or from automatic dwell timing.
//  Ports       : i_Clk         pixel clock, rising-edge logic
//                i_Rst         synchronous active-high reset
//                i_VSync       vertical sync, frame starts on its rising edge
//                i_Auto_En     advance automatically after DWELL_FRAMES frames
//                i_Hold        freeze dwell counter, block auto advance
//                i_Step        single-cycle manual advance request
//                o_Pattern     pattern select for the pattern generator
//                o_Frame_Start registered pulse, one cycle after a frame start
//                o_Wrap        pulse together with a wrapping pattern update
//                o_Dwell_Count current dwell counter value
//  Config      : define PATTERN_SEQ_SKIP_ZERO_EN to drop pattern 0 (generator
//                disabled) from the sequence; reset and wrap value become 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_sequencer #(
  parameter int NUM_PATTERNS = 7,   // 2..16
  parameter int DWELL_FRAMES = 60   // 1..255
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_VSync,
  input  logic       i_Auto_En,
  input  logic       i_Hold,
  input  logic       i_Step,
  output logic [3:0] o_Pattern,
  output logic       o_Frame_Start,
  output logic       o_Wrap,
  output logic [7:0] o_Dwell_Count
);

  localparam logic [3:0] C_LAST_PATTERN = 4'(NUM_PATTERNS - 1);
  localparam logic [7:0] C_DWELL_LAST   = 8'(DWELL_FRAMES - 1);
`ifdef PATTERN_SEQ_SKIP_ZERO_EN
  localparam logic [3:0] C_BASE_PATTERN = 4'd1;
`else
  localparam logic [3:0] C_BASE_PATTERN = 4'd0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        vsync_q, vsync_d;
  logic        seen_low_q, seen_low_d;
  logic        step_pending_q, step_pending_d;
  logic [3:0]  pattern_q, pattern_d;
  logic [7:0]  dwell_q, dwell_d;
  logic        frame_start_q, frame_start_d;
  logic        wrap_q, wrap_d;

  logic        w_frame_start;
  logic        w_step_req;
  logic        w_auto_due;
  logic        w_advance;

  // vsync_q is cleared by reset, so a VSync that is already high when reset
  // releases would look like a rising edge. seen_low_q only arms edge
  // detection once VSync has actually been observed low after reset.
  assign w_frame_start = i_VSync & ~vsync_q & seen_low_q;

  // A step arriving on the frame-start cycle itself is consumed immediately.
  assign w_step_req = step_pending_q | i_Step;
  assign w_auto_due = (state_q == ST_RUN) & i_Auto_En & ~i_Hold &
                      (dwell_q == C_DWELL_LAST);
  // Both causes OR together, so a simultaneous step and auto expiry give one
  // advance.
  assign w_advance  = w_frame_start & (w_step_req | w_auto_due);

  always_comb begin
    state_d        = state_q;
    vsync_d        = i_VSync;
    seen_low_d     = seen_low_q | ~i_VSync;
    step_pending_d = step_pending_q | i_Step;
    pattern_d      = pattern_q;
    dwell_d        = dwell_q;
    frame_start_d  = w_frame_start;
    wrap_d         = 1'b0;

    if (w_frame_start) begin
      // Every frame start consumes the pending step (it is either applied
      // now or there was none).
      step_pending_d = 1'b0;

      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          dwell_d = 8'd0;
        end
        ST_RUN: begin
          if (!i_Hold) begin
            dwell_d = dwell_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (w_advance) begin
        dwell_d = 8'd0;
        if (pattern_q == C_LAST_PATTERN) begin
          pattern_d = C_BASE_PATTERN;
          wrap_d    = 1'b1;
        end else begin
          pattern_d = pattern_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q        <= ST_IDLE;
      vsync_q        <= 1'b0;
      seen_low_q     <= 1'b0;
      step_pending_q <= 1'b0;
      pattern_q      <= C_BASE_PATTERN;
      dwell_q        <= 8'd0;
      frame_start_q  <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      vsync_q        <= vsync_d;
      seen_low_q     <= seen_low_d;
      step_pending_q <= step_pending_d;
      pattern_q      <= pattern_d;
      dwell_q        <= dwell_d;
      frame_start_q  <= frame_start_d;
      wrap_q         <= wrap_d;
    end
  end

  assign o_Pattern     = pattern_q;
  assign o_Frame_Start = frame_start_q;
  assign o_Wrap        = wrap_q;
  assign o_Dwell_Count = dwell_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_sequencer
//  Description : Self-checking bench for pattern_sequencer (NUM_PATTERNS=7,
//                DWELL_FRAMES=3). Each driven cycle pushes its expected
//                outputs to a queue; a monitor pops and compares them after
//                the following rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_sequencer;

  localparam int NP = 7;
  localparam int DW = 3;
`ifdef PATTERN_SEQ_SKIP_ZERO_EN
  localparam logic [3:0] R    = 4'd1;
  localparam int         NSEQ = NP - 1;
`else
  localparam logic [3:0] R    = 4'd0;
  localparam int         NSEQ = NP;
`endif

  logic       clk;
  logic       i_Rst, i_VSync, i_Auto_En, i_Hold, i_Step;
  logic [3:0] o_Pattern;
  logic       o_Frame_Start, o_Wrap;
  logic [7:0] o_Dwell_Count;

  pattern_sequencer #(
    .NUM_PATTERNS(NP),
    .DWELL_FRAMES(DW)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (i_Rst),
    .i_VSync      (i_VSync),
    .i_Auto_En    (i_Auto_En),
    .i_Hold       (i_Hold),
    .i_Step       (i_Step),
    .o_Pattern    (o_Pattern),
    .o_Frame_Start(o_Frame_Start),
    .o_Wrap       (o_Wrap),
    .o_Dwell_Count(o_Dwell_Count)
  );

  typedef struct {
    logic       rst, vs, au, ho, st;
    logic [3:0] pat;
    logic [7:0] dw;
    logic       fs, wr;
  } vec_t;

  typedef struct {
    logic [3:0] pat;
    logic [7:0] dw;
    logic       fs, wr;
    int         id;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic rst, input logic vs, input logic au,
                              input logic ho, input logic st,
                              input logic [3:0] pat, input logic [7:0] dw,
                              input logic fs, input logic wr);
    vec_t v;
    v.rst = rst; v.vs = vs; v.au = au; v.ho = ho; v.st = st;
    v.pat = pat; v.dw = dw; v.fs = fs; v.wr = wr;
    return v;
  endfunction

  // Apply inputs away from the active edge and record what the DUT must show
  // after the next rising edge.
  task automatic drive(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    i_Rst     = v.rst;
    i_VSync   = v.vs;
    i_Auto_En = v.au;
    i_Hold    = v.ho;
    i_Step    = v.st;
    e.pat = v.pat; e.dw = v.dw; e.fs = v.fs; e.wr = v.wr; e.id = id;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      if (o_Pattern !== mon_e.pat) begin
        n_err++;
        $display("FAIL pattern vec %0d: got %0d expected %0d", mon_e.id, o_Pattern, mon_e.pat);
      end
      if (o_Dwell_Count !== mon_e.dw) begin
        n_err++;
        $display("FAIL dwell vec %0d: got %0d expected %0d", mon_e.id, o_Dwell_Count, mon_e.dw);
      end
      if (o_Frame_Start !== mon_e.fs) begin
        n_err++;
        $display("FAIL frame_start vec %0d: got %b expected %b", mon_e.id, o_Frame_Start, mon_e.fs);
      end
      if (o_Wrap !== mon_e.wr) begin
        n_err++;
        $display("FAIL wrap vec %0d: got %b expected %b", mon_e.id, o_Wrap, mon_e.wr);
      end
    end
  end

  initial begin
    logic [3:0] p;
    logic [7:0] d;
    logic       w;

    i_Rst = 1'b1; i_VSync = 1'b0; i_Auto_En = 1'b0; i_Hold = 1'b0; i_Step = 1'b0;

    //              rst vs au ho st  pattern  dwell fs wr
    // Reset, then a step pending in IDLE applied on the IDLE->RUN frame start
    tbl.push_back(mk(1, 1, 0, 0, 0, R,       0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, R,       0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, R,       0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, R + 4'd1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, R + 4'd1, 0, 0, 0));
    // Three steps inside one frame collapse into one advance
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(0, 0, 0, 0, 1, R + 4'd1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, R + 4'd1, 0, 0, 0));
    end
    tbl.push_back(mk(0, 1, 0, 0, 0, R + 4'd2, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, R + 4'd2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, R + 4'd2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, R + 4'd2, 1, 1, 0));
    // Auto on; step coincides with the frame start where dwell = 2
    tbl.push_back(mk(0, 0, 1, 0, 0, R + 4'd2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, R + 4'd2, 2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, R + 4'd2, 2, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, R + 4'd3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, R + 4'd3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, R + 4'd3, 1, 1, 0));
    // Auto toggled mid-frame keeps the dwell count
    tbl.push_back(mk(0, 0, 0, 0, 0, R + 4'd3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, R + 4'd3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, R + 4'd3, 2, 1, 0));
    // Hold for five frames: counter and pattern frozen, frame starts still pulse
    tbl.push_back(mk(0, 0, 1, 1, 0, R + 4'd3, 2, 0, 0));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(0, 1, 1, 1, 0, R + 4'd3, 2, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, R + 4'd3, 2, 0, 0));
    end
    // Step during hold advances at the next frame
    tbl.push_back(mk(0, 0, 1, 1, 1, R + 4'd3, 2, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, R + 4'd4, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, R + 4'd4, 0, 0, 0));
    // Reset on a rising VSync in RUN wins; VSync high at release is not a frame start
    tbl.push_back(mk(1, 1, 0, 0, 0, R,       0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, R,       0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, R,       0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, R,       0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, R,       0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, R,       0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, R,       0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, R,       1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, R,       1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i], i);
    end

    // Auto cycling over 25 frames: first frame start enters RUN, then an
    // advance every DW frames, wrapping once back to the base pattern.
    drive(mk(1, 0, 1, 0, 0, R, 0, 0, 0), 1000);
    drive(mk(0, 0, 1, 0, 0, R, 0, 0, 0), 1001);
    for (int k = 1; k <= 25; k++) begin
      p = R + 4'(((k - 1) / DW) % NSEQ);
      d = 8'((k - 1) % DW);
      w = (k > DW) && ((k - 1) % DW == 0) && (((k - 1) / DW) % NSEQ == 0);
      drive(mk(0, 1, 1, 0, 0, p, d, 1, w), 1000 + 4 * k);
      drive(mk(0, 1, 1, 0, 0, p, d, 0, 0), 1001 + 4 * k);
      drive(mk(0, 0, 1, 0, 0, p, d, 0, 0), 1002 + 4 * k);
      drive(mk(0, 0, 1, 0, 0, p, d, 0, 0), 1003 + 4 * k);
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected results left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter NUM_PATTERNS, default 7: number of selectable patterns, legal range 2..16; pattern indices are 0..NUM_PATTERNS-1.
REQ-002 Parameter DWELL_FRAMES, default 60: frames each pattern is shown in auto mode, legal range 1..255.
REQ-003 i_Clk  input  1  pixel clock; all logic is on its rising edge.
REQ-004 i_Rst  input  1  reset, synchronous, active-high.
REQ-005 i_VSync  input  1  vertical sync from the sync generator; a frame starts on its rising edge.
REQ-006 i_Auto_En  input  1  1 = advance the pattern automatically after DWELL_FRAMES frames.
REQ-007 i_Hold  input  1  1 = freeze the dwell counter and block auto advance.
REQ-008 i_Step  input  1  single-cycle manual advance request (debounced upstream).
REQ-009 o_Pattern  output  4  pattern select driven to the test pattern generator's i_Pattern.
REQ-010 o_Frame_Start  output  1  one-cycle pulse, registered, one cycle after each detected frame start.
REQ-011 o_Wrap  output  1  one-cycle pulse coincident with an advance that wraps the sequence.
REQ-012 o_Dwell_Count  output  8  current dwell counter value.

Function
REQ-013 The block SHALL register i_VSync into r_VSync; frame_start = i_VSync AND NOT r_VSync, evaluated each cycle.
REQ-014 The state machine SHALL have two states: IDLE (after reset) and RUN.
REQ-015 In IDLE, o_Pattern SHALL hold its reset value, the dwell counter SHALL hold 0, and the first frame_start SHALL move the state to RUN.
REQ-016 Any i_Step pulse in either state SHALL set a step_pending flag; multiple pulses within one frame SHALL collapse into one advance.
REQ-017 In RUN, on frame_start the dwell counter SHALL increment unless i_Hold=1, in which case it holds its value.
REQ-018 An advance SHALL occur on frame_start when step_pending=1, or when i_Auto_En=1, i_Hold=0 and the dwell counter equals DWELL_FRAMES-1.
REQ-019 When both advance conditions are true on the same frame_start, exactly one advance SHALL occur.
REQ-020 On an advance, o_Pattern SHALL update on the clock edge where frame_start is true (visible the next cycle), the dwell counter SHALL reset to 0, and step_pending SHALL clear.
REQ-021 An i_Step arriving in the same cycle as frame_start SHALL be applied at that frame_start and SHALL NOT leave step_pending set.
REQ-022 The pending step taken into account by the IDLE->RUN transition SHALL be applied at that same frame_start.
REQ-023 Advance arithmetic: next = o_Pattern+1; if o_Pattern = NUM_PATTERNS-1, next = wrap value (REQ-031/032) and o_Wrap SHALL pulse with the update.
REQ-024 o_Pattern SHALL never change except on a frame_start cycle, so a pattern is never switched mid-frame.
REQ-025 o_Frame_Start SHALL pulse for every frame_start, including in IDLE and while i_Hold=1.
REQ-026 Toggling i_Auto_En mid-frame SHALL NOT reset the dwell counter.

Reset
REQ-027 With i_Rst=1 at a clock edge: state=IDLE, o_Pattern=reset value (REQ-031/032), dwell counter=0, step_pending=0, r_VSync=0, o_Frame_Start=0, o_Wrap=0.
REQ-028 Reset SHALL take priority over every other event, including an advance due in the same cycle.
REQ-029 After reset deasserts, a frame_start SHALL be recognised only on a genuine 0->1 transition of i_VSync; if i_VSync is high when reset releases, it SHALL NOT count as a frame start.

Configuration
REQ-030 Macro PATTERN_SEQ_SKIP_ZERO_EN selects whether pattern 0 (generator disabled) is part of the sequence.
REQ-031 With PATTERN_SEQ_SKIP_ZERO_EN defined: reset value = 1, wrap value = 1, and pattern 0 is never output.
REQ-032 With PATTERN_SEQ_SKIP_ZERO_EN undefined: reset value = 0, wrap value = 0.

Verification (NUM_PATTERNS=7, DWELL_FRAMES=3)
REQ-033 Auto cycling: reset, i_Auto_En=1, 25 VSync rising edges -> 1st edge enters RUN; o_Pattern advances every 3rd frame after that, 0->1->...->6->0; o_Wrap pulses once at 6->0.
REQ-034 Collapsed steps: i_Auto_En=0, 3 i_Step pulses inside one frame -> exactly one advance at the next frame_start; o_Pattern stays unchanged between frame starts.
REQ-035 Simultaneous events: i_Step on the same cycle as the frame_start where the dwell counter equals 2, with auto enabled -> a single advance, dwell counter=0, step_pending=0.
REQ-036 Hold: i_Hold=1 for 5 frames in auto mode -> o_Pattern and o_Dwell_Count are constant and o_Frame_Start pulses 5 times; a step during hold still advances at the next frame.
REQ-037 Reset during operation: i_Rst asserted in RUN with o_Pattern=4 and i_VSync high at release -> o_Pattern=0, IDLE state, no frame_start until i_VSync falls and rises again.
REQ-038 Skip-zero build: with PATTERN_SEQ_SKIP_ZERO_EN defined, rerun REQ-033 -> reset value 1, sequence wraps 6->1, value 0 never observed.
